a3_fetch_controller: RTL and testbench

A3_FETCH_CONTROLLER -- requirements
Module: a3_fetch_controller

---
 rtl/a3_fetch_pkg.sv | 14 +
 rtl/a3_fetch_controller_ifid.sv | 32 +++
 rtl/a3_fetch_controller.sv | 112 +++++++++++
 tb/tb_a3_fetch_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/a3_fetch_pkg.sv
// Shared definitions for the A3 instruction fetch controller: state encoding and default widths.
package a3_fetch_pkg;

    localparam int DEF_PROG_LEN = 6;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/a3_fetch_controller_ifid.sv
// IF/ID pipeline register: clear (flush/consume) beats load, otherwise it holds.
module a3_ifid_reg #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [ADDR_W-1:0]  d_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (clear) begin
            // instr/instr_pc keep their stale contents; only validity matters
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= d_instr;
            instr_pc    <= d_pc;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/a3_fetch_controller.sv
// A3 fetch controller: IDLE/RUN/HALT FSM, PC and redirect handling feeding the IF/ID register.
// Optional macro FETCH_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module a3_fetch_controller
    import a3_fetch_pkg::*;
#(
    parameter int PROG_LEN = DEF_PROG_LEN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic               bad_target
`ifdef FETCH_STALL_CNT_EN
    ,output logic [15:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W:0]   PROG_END = (ADDR_W + 1)'(PROG_LEN);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              load, clear, bad_set;
    logic              target_ok;

    assign target_ok = ({1'b0, br_target} < PROG_END);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= '0;
            bad_target <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (bad_set) bad_target <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        clear      = 1'b0;
        bad_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN, HALT: begin
                // a redirect squashes whatever is in IF/ID and suppresses this edge's fetch
                if (br_taken) begin
                    pc_next = br_target;
                    clear   = 1'b1;
                    if (target_ok) begin
                        state_next = RUN;
                    end else begin
                        state_next = HALT;
                        bad_set    = 1'b1;
                    end
                end else if (state == RUN) begin
                    if (!instr_valid || id_ready) begin
                        load    = 1'b1;
                        pc_next = pc + 1'b1;
                        if (pc == LAST_PC) state_next = HALT;
                    end
                end else if (id_ready) begin
                    clear = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    a3_ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ifid (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .clear       (clear),
        .d_instr     (imem_rdata),
        .d_pc        (pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((state != IDLE) && instr_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_a3_fetch_controller.sv
// Directed bench for a3_fetch_controller: straight-line run, stall, redirects, halt and async reset.
module tb_a3_fetch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       br_taken;
    logic [7:0] br_target;
    logic       id_ready;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       halted;
    logic       bad_target;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // program memory: 0x10..0x15 at 0..5, filler elsewhere
    assign imem_rdata = (imem_addr < 8'd6) ? (8'h10 + imem_addr) : 8'hEE;

    a3_fetch_controller dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .id_ready    (id_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted),
        .bad_target  (bad_target)
`ifdef FETCH_STALL_CNT_EN
        ,.stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
        #1;
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_bad", 32'(bad_target), 0);
        #12 reset = 1'b1;

        // straight-line run through the whole program
        start = 1'b1; id_ready = 1'b1;
        step();
        start = 1'b0;
        chk("start_valid", 32'(instr_valid), 0);
        chk("start_addr", 32'(imem_addr), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("run_instr", 32'(instr), 32'h10 + i);
            chk("run_pc", 32'(instr_pc), i);
            chk("run_valid", 32'(instr_valid), 1);
            chk("run_halted", 32'(halted), (i == 5) ? 1 : 0);
        end
        step();
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_halted", 32'(halted), 1);

        // restart from HALT via redirect to 0
        br_taken = 1'b1; br_target = 8'd0;
        step();
        br_taken = 1'b0;
        chk("rd0_halted", 32'(halted), 0);
        chk("rd0_valid", 32'(instr_valid), 0);
        chk("rd0_addr", 32'(imem_addr), 0);
        step();
        chk("rd0_pc0", 32'(instr_pc), 0);
        chk("rd0_instr", 32'(instr), 32'h10);
        step();
        step();
        chk("pre_stall_pc", 32'(instr_pc), 2);

        // three-cycle stall while instr_pc=2
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(instr_pc), 2);
            chk("stall_instr", 32'(instr), 32'h12);
            chk("stall_addr", 32'(imem_addr), 3);
            chk("stall_valid", 32'(instr_valid), 1);
        end
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 3);
`endif
        id_ready = 1'b1;
        step();
        chk("resume_pc", 32'(instr_pc), 3);
        chk("resume_instr", 32'(instr), 32'h13);
        step();
        chk("pre_br_pc", 32'(instr_pc), 4);

        // redirect to 1 while instr_pc=4 is being consumed
        br_taken = 1'b1; br_target = 8'd1;
        step();
        br_taken = 1'b0;
        chk("br1_valid", 32'(instr_valid), 0);
        chk("br1_addr", 32'(imem_addr), 1);
        step();
        chk("br1_pc", 32'(instr_pc), 1);
        chk("br1_instr", 32'(instr), 32'h11);
        chk("br1_v", 32'(instr_valid), 1);

        // out-of-range redirect; start must be ignored in HALT
        br_taken = 1'b1; br_target = 8'd9;
        step();
        br_taken = 1'b0; start = 1'b1;
        chk("bad_halted", 32'(halted), 1);
        chk("bad_flag", 32'(bad_target), 1);
        chk("bad_valid", 32'(instr_valid), 0);
        chk("bad_addr", 32'(imem_addr), 9);
        step();
        start = 1'b0;
        chk("bad_nofetch", 32'(instr_valid), 0);
        chk("bad_still", 32'(halted), 1);

        // redirect to the last valid address: one fetch then HALT
        br_taken = 1'b1; br_target = 8'd5;
        step();
        br_taken = 1'b0;
        chk("last_halted", 32'(halted), 0);
        chk("last_sticky", 32'(bad_target), 1);
        step();
        chk("last_instr", 32'(instr), 32'h15);
        chk("last_halt", 32'(halted), 1);

        // async reset in the middle of a stall
        br_taken = 1'b1; br_target = 8'd0; id_ready = 1'b0;
        step();
        br_taken = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 32'(instr_valid), 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_instr", 32'(instr), 0);
        chk("arst_pc", 32'(instr_pc), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_bad", 32'(bad_target), 0);
        chk("arst_halted", 32'(halted), 0);
`ifdef FETCH_STALL_CNT_EN
        chk("arst_cnt", 32'(stall_cnt), 0);
`endif
        #2 reset = 1'b1;

        // IDLE ignores redirects and waits for start
        br_taken = 1'b1; br_target = 8'd3; id_ready = 1'b1;
        step();
        step();
        br_taken = 1'b0;
        chk("idle_addr", 32'(imem_addr), 0);
        chk("idle_valid", 32'(instr_valid), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("restart_pc", 32'(instr_pc), 0);
        chk("restart_instr", 32'(instr), 32'h10);
        chk("restart_valid", 32'(instr_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
